// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM core.
//   DUTY_MAX  - largest accepted duty value (percent)
//   eng_state_t - states of the serial threshold engine
//   prod_w()  - width of the period*duty product
//   pow5_lut() - period multiplier 5^idx for idx = 0..3
package pwm_pkg;

    localparam int DUTY_MAX = 100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_STORE,
        ST_DONE
    } eng_state_t;

    // A 7-bit duty times a CNT_W-bit period needs CNT_W+7 bits.
    function automatic int prod_w(input int cnt_w);
        return cnt_w + 7;
    endfunction

    function automatic logic [6:0] pow5_lut(input logic [1:0] idx);
        case (idx)
            2'd0:    return 7'd1;
            2'd1:    return 7'd5;
            2'd2:    return 7'd25;
            default: return 7'd125;
        endcase
    endfunction

endpackage

// File: rtl/pwm_multi_core_if.sv
// pwm_multi_core_if: configuration bus of the multi-channel PWM core.
//   cfg_we/cfg_ch/cfg_duty - per-channel duty write (percent)
//   per_we/per_pow2/per_pow5 - period scale write
//   cfg_busy - engine running or a staged set awaits its period boundary
// master drives the writes, slave is the PWM core.
interface pwm_multi_core_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            cfg_we;
    logic [CH_W-1:0] cfg_ch;
    logic [6:0]      cfg_duty;
    logic            per_we;
    logic [1:0]      per_pow2;
    logic [1:0]      per_pow5;
    logic            cfg_busy;

    modport master (
        output cfg_we, cfg_ch, cfg_duty, per_we, per_pow2, per_pow5,
        input  cfg_busy
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_duty, per_we, per_pow2, per_pow5,
        output cfg_busy
    );
endinterface

// File: rtl/pwm_div100.sv
// pwm_div100: serial restoring divider by 100, one quotient bit per clock.
//   start    - load dividend and begin (ignored while running)
//   dividend - W-bit unsigned value
//   done     - high in the cycle that computes the last quotient bit;
//              quotient is final from the following cycle on
//   quotient - low QW bits of floor(dividend / 100)
module pwm_div100
    import pwm_pkg::*;
#(
    parameter int W  = 39,
    parameter int QW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int CW = $clog2(W + 1);

    // shreg shifts dividend bits out at the top and quotient bits in at the bottom
    logic [W-1:0]  shreg;
    logic [6:0]    rem;
    logic [CW-1:0] cnt;
    logic          running;
    logic [7:0]    trial;
    logic          fits;

    always_comb begin
        trial = {rem, shreg[W-1]};
        fits  = (trial >= 8'(DUTY_MAX));
    end

    assign done     = running && (cnt == CW'(1));
    assign quotient = shreg[QW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            rem     <= '0;
        end else if (start && !running) begin
            shreg   <= dividend;
            rem     <= '0;
            cnt     <= CW'(W);
            running <= 1'b1;
        end else if (running) begin
            shreg <= {shreg[W-2:0], fits};
            rem   <= fits ? 7'(trial - 8'(DUTY_MAX)) : trial[6:0];
            cnt   <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                running <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pwm_multi_core.sv
// pwm_multi_core: NUM_CH PWM outputs sharing one period counter.
//   clk, rst     - clock, synchronous active-high reset
//   cfg          - configuration bus (slave side): duty/period writes, cfg_busy
//   period_start - high in the cycle where the counter is 0
//   period_count - active period length in clk cycles
//   pwm_out      - registered PWM outputs, one cycle behind the counter
// Writes land in shadow registers; a serial engine turns them into on/start
// tick thresholds, and the whole set is swapped in at a period boundary.
module pwm_multi_core
    import pwm_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                CNT_W       = 32,
    parameter int                BASE_DIV    = 1000,
    parameter logic [NUM_CH-1:0] CENTER_MASK = 4'hF,
    parameter logic [NUM_CH-1:0] POL_MASK    = 4'h0
) (
    input  logic               clk,
    input  logic               rst,
    pwm_multi_core_if.slave    cfg,
    output logic               period_start,
    output logic [CNT_W-1:0]   period_count,
    output logic [NUM_CH-1:0]  pwm_out
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = prod_w(CNT_W);

    function automatic logic [CNT_W-1:0] period_of(input logic [1:0] p2,
                                                   input logic [1:0] p5);
        logic [CNT_W-1:0] base;
        base = CNT_W'(BASE_DIV) << p2;
        return base * CNT_W'(pow5_lut(p5));
    endfunction

    // shadow registers
    logic [6:0]        shadow_duty [NUM_CH];
    logic [1:0]        shadow_pow2;
    logic [1:0]        shadow_pow5;
    logic              dirty;
    logic              duty_wr;

    // engine
    eng_state_t        state;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  snap_p;
    logic [6:0]        snap_duty [NUM_CH];
    logic [CNT_W-1:0]  staged_on [NUM_CH];
    logic [CNT_W-1:0]  staged_start [NUM_CH];
    logic [CNT_W-1:0]  staged_p;
    logic              staged_valid;
    logic              pass_start;
    logic              div_start;
    logic [PROD_W-1:0] div_dividend;
    logic              div_done;
    logic [CNT_W-1:0]  div_quot;

    // active set, counter and compare
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  act_on [NUM_CH];
    logic [CNT_W-1:0]  act_start [NUM_CH];
    logic              wrap;
    logic              commit;
    logic [NUM_CH-1:0] raw;

    assign duty_wr    = cfg.cfg_we && (cfg.cfg_duty <= 7'(DUTY_MAX))
                        && (int'(cfg.cfg_ch) < NUM_CH);
    // A pass may only begin once the previous staged set has been committed.
    assign pass_start = (state == ST_IDLE) && dirty && !staged_valid;
    assign cfg.cfg_busy = (state != ST_IDLE) || dirty || staged_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty       <= 1'b0;
            shadow_pow2 <= '0;
            shadow_pow5 <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty[i] <= '0;
            end
        end else begin
            if (duty_wr) begin
                shadow_duty[cfg.cfg_ch] <= cfg.cfg_duty;
            end
            if (cfg.per_we) begin
                shadow_pow2 <= cfg.per_pow2;
                shadow_pow5 <= cfg.per_pow5;
            end
            // A write in the same cycle as the snapshot keeps dirty set, so the
            // pass that just started will be discarded and rerun.
            if (duty_wr || cfg.per_we) begin
                dirty <= 1'b1;
            end else if (pass_start) begin
                dirty <= 1'b0;
            end
        end
    end

    // The divider is loaded at the end of MUL, so DIV lasts exactly PROD_W cycles.
    assign div_start    = (state == ST_MUL);
    assign div_dividend = PROD_W'(snap_p) * PROD_W'(snap_duty[ch]);

    pwm_div100 #(
        .W  (PROD_W),
        .QW (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ch           <= '0;
            snap_p       <= CNT_W'(BASE_DIV);
            staged_p     <= CNT_W'(BASE_DIV);
            staged_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_duty[i]    <= '0;
                staged_on[i]    <= '0;
                staged_start[i] <= '0;
            end
        end else begin
            if (commit) begin
                staged_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pass_start) begin
                        snap_p <= period_of(shadow_pow2, shadow_pow5);
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap_duty[i] <= shadow_duty[i];
                        end
                        ch    <= '0;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    staged_on[ch]    <= div_quot;
                    staged_start[ch] <= CENTER_MASK[ch] ? ((snap_p - div_quot) >> 1) : '0;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        ch    <= ch + CH_W'(1);
                        state <= ST_MUL;
                    end
                end
                ST_DONE: begin
                    // A write during the pass makes this set stale: drop it.
                    if (!dirty) begin
                        staged_valid <= 1'b1;
                        staged_p     <= snap_p;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wrap   = (count == period_count - CNT_W'(1));
    assign commit = wrap && staged_valid;

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (act_on[i] != '0) && (count >= act_start[i])
                     && (count < act_start[i] + act_on[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            period_count <= CNT_W'(BASE_DIV);
            period_start <= 1'b0;
            pwm_out      <= POL_MASK;
            for (int i = 0; i < NUM_CH; i++) begin
                act_on[i]    <= '0;
                act_start[i] <= '0;
            end
        end else begin
            count        <= wrap ? '0 : count + CNT_W'(1);
            period_start <= wrap;
            pwm_out      <= raw ^ POL_MASK;
            if (commit) begin
                period_count <= staged_p;
                for (int i = 0; i < NUM_CH; i++) begin
                    act_on[i]    <= staged_on[i];
                    act_start[i] <= staged_start[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_multi_core.sv
// Self-checking bench for pwm_multi_core: a behavioural model tracks shadow
// writes, pass timing and period-boundary commits; a compare process checks
// every output on every cycle, and directed steps pin literal waveforms.
module tb_pwm_multi_core;
    localparam int              NUM_CH      = 4;
    localparam int              CNT_W       = 32;
    localparam int              BASE_DIV    = 10;
    localparam logic [3:0]      CENTER_MASK = 4'b0101;
    localparam logic [3:0]      POL_MASK    = 4'b0000;
    // per channel: MUL + (CNT_W+7) DIV cycles + STORE, then one DONE cycle
    localparam int              PASS_LEN    = NUM_CH * (CNT_W + 7 + 2) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             period_start;
    logic [CNT_W-1:0] period_count;
    logic [3:0]       pwm_out;

    pwm_multi_core_if #(.NUM_CH(NUM_CH)) bus ();

    pwm_multi_core #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .BASE_DIV    (BASE_DIV),
        .CENTER_MASK (CENTER_MASK),
        .POL_MASK    (POL_MASK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (bus),
        .period_start (period_start),
        .period_count (period_count),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int   m_count, m_per, m_rem, m_snap_p, m_st_p, m_sh_p2, m_sh_p5;
    int   m_on[NUM_CH], m_start[NUM_CH], m_sh_duty[NUM_CH], m_snap_duty[NUM_CH];
    int   m_st_on[NUM_CH], m_st_start[NUM_CH];
    bit   m_dirty, m_busy, m_sv, m_wrap, m_begin, m_old_dirty, m_wr_ok;
    logic [3:0] e_pwm;
    bit   e_ps;
    int   m_tmp;

    function automatic int per_of(input int p2, input int p5);
        int f = 1;
        for (int k = 0; k < p5; k++) f = f * 5;
        return (BASE_DIV << p2) * f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_per = BASE_DIV; m_rem = 0; m_snap_p = BASE_DIV; m_st_p = BASE_DIV;
            m_sh_p2 = 0; m_sh_p5 = 0; m_dirty = 0; m_busy = 0; m_sv = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_on[i] = 0; m_start[i] = 0; m_sh_duty[i] = 0; m_snap_duty[i] = 0;
                m_st_on[i] = 0; m_st_start[i] = 0;
            end
            e_pwm = POL_MASK; e_ps = 0;
        end else begin
            m_wrap = (m_count == m_per - 1);
            for (int i = 0; i < NUM_CH; i++)
                e_pwm[i] = ((m_on[i] != 0) && (m_count >= m_start[i]) &&
                            (m_count < m_start[i] + m_on[i])) ^ POL_MASK[i];
            e_ps = m_wrap;
            m_old_dirty = m_dirty;
            m_begin = !m_busy && m_dirty && !m_sv;
            if (m_wrap && m_sv) begin
                m_per = m_st_p;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_on[i] = m_st_on[i]; m_start[i] = m_st_start[i];
                end
                m_sv = 0;
            end
            m_count = m_wrap ? 0 : m_count + 1;
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_busy = 0;
                    if (!m_old_dirty) begin
                        m_st_p = m_snap_p;
                        for (int i = 0; i < NUM_CH; i++) begin
                            m_tmp = (m_snap_p * m_snap_duty[i]) / 100;
                            m_st_on[i] = m_tmp;
                            m_st_start[i] = CENTER_MASK[i] ? (m_snap_p - m_tmp) / 2 : 0;
                        end
                        m_sv = 1;
                    end
                end else m_rem--;
            end else if (m_begin) begin
                m_busy = 1; m_rem = PASS_LEN;
                m_snap_p = per_of(m_sh_p2, m_sh_p5);
                for (int i = 0; i < NUM_CH; i++) m_snap_duty[i] = m_sh_duty[i];
            end
            m_wr_ok = bus.cfg_we && (int'(bus.cfg_duty) <= 100) && (int'(bus.cfg_ch) < NUM_CH);
            if (m_wr_ok) m_sh_duty[bus.cfg_ch] = int'(bus.cfg_duty);
            if (bus.per_we) begin
                m_sh_p2 = int'(bus.per_pow2); m_sh_p5 = int'(bus.per_pow5);
            end
            if (m_wr_ok || bus.per_we) m_dirty = 1;
            else if (m_begin) m_dirty = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pwm_out", pwm_out, e_pwm);
            chk("period_start", period_start, e_ps);
            chk("period_count", period_count, m_per);
            chk("cfg_busy", bus.cfg_busy, m_busy | m_dirty | m_sv);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_duty(input int c, input int d);
        bus.cfg_ch = 2'(c); bus.cfg_duty = 7'(d); bus.cfg_we = 1'b1;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic wr_per(input int p2, input int p5);
        bus.per_pow2 = 2'(p2); bus.per_pow5 = 2'(p5); bus.per_we = 1'b1;
        @(negedge clk);
        bus.per_we = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!bus.cfg_busy) break;
        end
        chk("idle_reached", bus.cfg_busy, 1'b0);
    endtask

    task automatic wait_ps();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (period_start) break;
        end
        chk("period_start_seen", period_start, 1'b1);
    endtask

    task automatic sample(input int c, input int len, output logic [31:0] pat);
        logic [3:0] v;
        pat = '0;
        wait_ps();
        for (int k = 0; k < len; k++) begin
            if (k != 0) @(negedge clk);
            v = pwm_out;
            pat[k] = v[c];
        end
    endtask

    task automatic spacing(output int n);
        wait_ps();
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n++;
            if (period_start) break;
        end
    endtask

    logic [31:0] pat;
    int          sp;

    initial begin
        bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_duty = 0;
        bus.per_we = 0; bus.per_pow2 = 0; bus.per_pow5 = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        rst = 0;
        chk("reset_pwm", pwm_out, 4'h0);
        chk("reset_period_count", period_count, 10);
        chk("reset_busy", bus.cfg_busy, 1'b0);
        chk("reset_period_start", period_start, 1'b0);

        // 50% on center-aligned ch0: on=5 start=2
        wr_duty(0, 50);
        wait_idle();
        sample(0, 10, pat);
        chk("ch0_50_center", pat, 32'h0000_00F8);
        chk("p10", period_count, 10);

        // 30% then 0% on edge-aligned ch1
        wr_duty(1, 30);
        wait_idle();
        sample(1, 10, pat);
        chk("ch1_30_edge", pat, 32'h0000_000E);
        wr_duty(1, 0);
        wait_idle();
        sample(1, 10, pat);
        chk("ch1_0", pat, 32'h0);

        // 101% is ignored: nothing becomes dirty
        wr_duty(3, 101);
        chk("ch3_101_not_dirty", bus.cfg_busy, 1'b0);
        wr_duty(2, 100);
        wait_idle();
        sample(2, 10, pat);
        chk("ch2_100", pat, 32'h0000_03FF);
        sample(3, 10, pat);
        chk("ch3_kept", pat, 32'h0);

        // period doubling mid-period
        wait_ps();
        repeat (4) @(negedge clk);
        wr_per(1, 0);
        spacing(sp);
        chk("spacing_before", sp, 10);
        wait_idle();
        spacing(sp);
        chk("spacing_after", sp, 20);
        chk("p20", period_count, 20);
        sample(0, 20, pat);
        chk("ch0_50_p20", pat, 32'h0000_FFC0);

        // second write lands during DIV: first pass discarded
        wr_duty(0, 70);
        repeat (40) @(negedge clk);
        wr_duty(1, 40);
        wait_idle();
        sample(0, 20, pat);
        chk("ch0_70_p20", pat, 32'h0003_FFF0);
        sample(1, 20, pat);
        chk("ch1_40_p20", pat, 32'h0000_01FE);

        // randomized writes
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 5) == 0)
                wr_per(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            else
                wr_duty(int'($urandom_range(0, 3)), int'($urandom_range(0, 105)));
            repeat ($urandom_range(0, 80)) @(negedge clk);
        end
        wait_idle();
        repeat (120) @(negedge clk);

        // reset while the engine is in DIV with nothing staged
        wr_duty(0, 20);
        repeat (20) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_pwm", pwm_out, 4'h0);
        chk("rst_period_count", period_count, 10);
        chk("rst_busy", bus.cfg_busy, 1'b0);
        chk("rst_period_start", period_start, 1'b0);
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
